// File: rtl/iob_port_arbiter.sv
// Two-requester arbiter in front of a shared cache port, one outstanding transaction.
// Define IOB_ARB_RR_EN for round-robin on simultaneous requests; fixed m0 priority otherwise.
module iob_port_arbiter #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                m0_valid_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_wstrb_i,
   output logic                m0_ready_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_valid_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_wstrb_i,
   output logic                m1_ready_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                s_valid_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_wstrb_o,
   input  logic                s_ready_i,
   input  logic                s_rvalid_i,
   input  logic [DATA_W-1:0]   s_rdata_i,
   output logic [1:0]          grant_o,
   output logic                busy_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  owner_q;   // 1: m1 owns the transaction
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  any_valid;
   logic                  win_m1;

   assign any_valid = m0_valid_i | m1_valid_i;

`ifdef IOB_ARB_RR_EN
   logic rr_q;   // 1: favour m1 on a tie

   assign win_m1 = m1_valid_i & (~m0_valid_i | rr_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q <= 1'b0;
      end else if (state_q == IDLE && any_valid) begin
         rr_q <= ~win_m1;
      end
   end
`else
   assign win_m1 = m1_valid_i & ~m0_valid_i;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_valid) begin
            owner_q <= win_m1;
            addr_q  <= win_m1 ? m1_addr_i  : m0_addr_i;
            wdata_q <= win_m1 ? m1_wdata_i : m0_wdata_i;
            wstrb_q <= win_m1 ? m1_wstrb_i : m0_wstrb_i;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      s_valid_o   = 1'b0;
      s_addr_o    = '0;
      s_wdata_o   = '0;
      s_wstrb_o   = '0;
      m0_ready_o  = 1'b0;
      m1_ready_o  = 1'b0;
      m0_rvalid_o = 1'b0;
      m1_rvalid_o = 1'b0;
      m0_rdata_o  = '0;
      m1_rdata_o  = '0;
      grant_o     = 2'b00;
      busy_o      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (any_valid) state_d = ISSUE;
         end
         ISSUE: begin
            grant_o    = {owner_q, ~owner_q};
            s_valid_o  = 1'b1;
            s_addr_o   = addr_q;
            s_wdata_o  = wdata_q;
            s_wstrb_o  = wstrb_q;
            m0_ready_o = ~owner_q & s_ready_i;
            m1_ready_o =  owner_q & s_ready_i;
            if (s_ready_i) state_d = (|wstrb_q) ? IDLE : WAIT_RD;
         end
         WAIT_RD: begin
            grant_o     = {owner_q, ~owner_q};
            m0_rvalid_o = ~owner_q & s_rvalid_i;
            m1_rvalid_o =  owner_q & s_rvalid_i;
            m0_rdata_o  = owner_q ? '0 : s_rdata_i;
            m1_rdata_o  = owner_q ? s_rdata_i : '0;
            if (s_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_iob_port_arbiter.sv
// Scoreboard bench for iob_port_arbiter: directed cases plus randomized request rounds.
`timescale 1ns/1ps
module tb_iob_port_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
`ifdef IOB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [3:0] wstrb; } req_t;
   typedef struct { bit owner; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [3:0] wstrb; } exp_s_t;
   typedef struct { bit owner; logic [DW-1:0] data; } exp_r_t;

   logic clk = 1'b0;
   logic reset_n;
   logic          mv[2];
   logic [AW-1:0] ma[2];
   logic [DW-1:0] mw[2];
   logic [3:0]    ms[2];
   logic          rdy[2];
   logic m0_ready_o, m0_rvalid_o, m1_ready_o, m1_rvalid_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          s_valid_o;
   logic [AW-1:0] s_addr_o;
   logic [DW-1:0] s_wdata_o;
   logic [3:0]    s_wstrb_o;
   logic          s_ready_i, s_rvalid_i;
   logic [DW-1:0] s_rdata_i;
   logic [1:0]    grant_o;
   logic          busy_o;

   bit            cache_auto = 1'b0;
   logic          dir_ready = 1'b0, dir_rvalid = 1'b0;
   logic [DW-1:0] dir_rdata = '0;
   logic          rnd_ready = 1'b0, rnd_rvalid = 1'b0;
   logic [DW-1:0] rnd_rdata = '0;
   logic [AW-1:0] last_rd_addr = '0;

   req_t   rq[2][$];
   exp_s_t exp_s[$];
   exp_r_t exp_r[$];
   bit     model_ptr = 1'b0;
   int     n_total = 0;
   int     n_pass  = 0;

   assign s_ready_i  = cache_auto ? rnd_ready  : dir_ready;
   assign s_rvalid_i = cache_auto ? rnd_rvalid : dir_rvalid;
   assign s_rdata_i  = cache_auto ? rnd_rdata  : dir_rdata;
   assign rdy[0] = m0_ready_o;
   assign rdy[1] = m1_ready_o;

   iob_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_valid_i(mv[0]), .m0_addr_i(ma[0]), .m0_wdata_i(mw[0]), .m0_wstrb_i(ms[0]),
      .m0_ready_o(m0_ready_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_valid_i(mv[1]), .m1_addr_i(ma[1]), .m1_wdata_i(mw[1]), .m1_wstrb_i(ms[1]),
      .m1_ready_o(m1_ready_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
      .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [DW-1:0] rfun(input logic [AW-1:0] a);
      return {a, 2'b11} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Cache model: random accept/return; read data is a function of the last accepted read address
   initial forever begin
      @(posedge clk); #1;
      rnd_ready  = ($urandom_range(0, 9) < 6);
      rnd_rvalid = ($urandom_range(0, 9) < 4);
      rnd_rdata  = rfun(last_rd_addr);
   end

   // Slave-side monitor
   always @(negedge clk) begin
      if (reset_n && !s_valid_o)
         check("s_idle_zero", 64'(|{s_addr_o, s_wdata_o, s_wstrb_o}), 64'd0);
      if (reset_n && s_valid_o && s_ready_i) begin
         if (s_wstrb_o == 4'h0) last_rd_addr = s_addr_o;
         if (exp_s.size() == 0) begin
            check("unexpected_issue", 64'(s_valid_o), 64'd0);
         end else begin
            exp_s_t e;
            e = exp_s.pop_front();
            check("s_addr",  64'(s_addr_o),  64'(e.addr));
            check("s_wdata", 64'(s_wdata_o), 64'(e.wdata));
            check("s_wstrb", 64'(s_wstrb_o), 64'(e.wstrb));
            check("grant",   64'(grant_o),   e.owner ? 64'd2 : 64'd1);
            check("ready",   64'({m1_ready_o, m0_ready_o}), e.owner ? 64'd2 : 64'd1);
         end
      end
   end

   // Requester-side read-return monitor
   always @(negedge clk) begin
      if (m0_rvalid_o || m1_rvalid_o) begin
         if (exp_r.size() == 0) begin
            check("unexpected_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'd0);
         end else begin
            exp_r_t e;
            e = exp_r.pop_front();
            check("rvalid_owner", 64'({m1_rvalid_o, m0_rvalid_o}), e.owner ? 64'd2 : 64'd1);
            check("rdata", 64'(e.owner ? m1_rdata_o : m0_rdata_o), 64'(e.data));
            check("rdata_nonowner", 64'(e.owner ? m0_rdata_o : m1_rdata_o), 64'd0);
         end
      end
   end

   // Reference: each requester presents its list back-to-back; every grant picks per the arbitration rule
   task automatic model_round();
      int i0 = 0;
      int i1 = 0;
      bit p1;
      req_t it;
      while (i0 < rq[0].size() || i1 < rq[1].size()) begin
         if (i0 < rq[0].size() && i1 < rq[1].size()) p1 = RR ? model_ptr : 1'b0;
         else p1 = (i1 < rq[1].size());
         if (p1) begin it = rq[1][i1]; i1++; end
         else    begin it = rq[0][i0]; i0++; end
         exp_s.push_back('{owner: p1, addr: it.addr, wdata: it.wdata, wstrb: it.wstrb});
         if (it.wstrb == 4'h0) exp_r.push_back('{owner: p1, data: rfun(it.addr)});
         model_ptr = !p1;
      end
   endtask

   task automatic drive(input int id);
      int cnt;
      for (int k = 0; k < rq[id].size(); k++) begin
         mv[id] = 1'b1; ma[id] = rq[id][k].addr; mw[id] = rq[id][k].wdata; ms[id] = rq[id][k].wstrb;
         cnt = 0;
         do begin @(negedge clk); cnt++; end while (!rdy[id] && cnt < 400);
         check("req_accepted", 64'(rdy[id]), 64'd1);
         if (!rdy[id]) break;
         @(posedge clk); #1;
      end
      mv[id] = 1'b0; ma[id] = '0; mw[id] = '0; ms[id] = '0;
   endtask

   task automatic run_round();
      int cnt = 0;
      model_round();
      fork
         drive(0);
         drive(1);
      join
      while ((exp_s.size() != 0 || exp_r.size() != 0 || busy_o) && cnt < 400) begin
         @(negedge clk); cnt++;
      end
      check("round_drained", 64'(exp_s.size() + exp_r.size()), 64'd0);
      @(posedge clk); #1;
      rq[0].delete(); rq[1].delete();
   endtask

   function automatic req_t rnd_req();
      req_t r;
      r.addr  = AW'($urandom);
      r.wdata = $urandom;
      r.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; end
      reset_n = 1'b0;
      #13;
      check("rst_busy",  64'(busy_o), 64'd0);
      check("rst_grant", 64'(grant_o), 64'd0);
      check("rst_outs",  64'(|{s_valid_o, m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o,
                               m0_rdata_o, m1_rdata_o}), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Read from m0 with immediate accept; spurious rvalid while idle
      dir_rvalid = 1'b1; dir_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("spur_idle_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'd0);
      check("spur_idle_busy", 64'(busy_o), 64'd0);
      @(posedge clk); #1;
      exp_s.push_back('{owner: 1'b0, addr: 30'h10, wdata: '0, wstrb: 4'h0});
      exp_r.push_back('{owner: 1'b0, data: 32'hDEADBEEF});
      mv[0] = 1'b1; ma[0] = 30'h10; mw[0] = '0; ms[0] = 4'h0;
      dir_rvalid = 1'b0; dir_ready = 1'b1;
      @(negedge clk);
      check("rd_latency_pre", 64'(s_valid_o), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rd_issue", 64'(s_valid_o), 64'd1);
      @(posedge clk); #1;
      mv[0] = 1'b0; ma[0] = '0; dir_ready = 1'b0;
      @(negedge clk);
      check("rd_svalid_one_cycle", 64'(s_valid_o), 64'd0);
      check("rd_wait_busy", 64'(busy_o), 64'd1);
      @(posedge clk); #1;
      dir_rvalid = 1'b1; dir_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rd_m0_rvalid", 64'(m0_rvalid_o), 64'd1);
      check("rd_m1_quiet", 64'({m1_ready_o, m1_rvalid_o, m1_rdata_o}), 64'd0);
      @(posedge clk); #1;
      dir_rvalid = 1'b0;
      @(negedge clk);
      check("rd_done_idle", 64'(busy_o), 64'd0);
      model_ptr = 1'b1;

      // Write from m1 held off for three cycles, spurious rvalid during ISSUE
      @(posedge clk); #1;
      exp_s.push_back('{owner: 1'b1, addr: 30'h20, wdata: 32'h12345678, wstrb: 4'hF});
      mv[1] = 1'b1; ma[1] = 30'h20; mw[1] = 32'h12345678; ms[1] = 4'hF;
      dir_rvalid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (c == 4) begin dir_ready = 1'b1; dir_rvalid = 1'b0; end
         @(negedge clk);
         check("wr_svalid", 64'(s_valid_o), 64'd1);
         check("wr_fields", {s_addr_o[29:0], s_wstrb_o}, {30'h20, 4'hF});
         check("wr_wdata", 64'(s_wdata_o), 64'h12345678);
         check("wr_m1_ready", 64'(m1_ready_o), 64'(c == 4));
         check("wr_no_rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'd0);
      end
      @(posedge clk); #1;
      mv[1] = 1'b0; ma[1] = '0; mw[1] = '0; ms[1] = '0; dir_ready = 1'b0;
      @(negedge clk);
      check("wr_idle_after", 64'({busy_o, grant_o}), 64'd0);
      model_ptr = 1'b0;

      // Reset while waiting for read data; late return must be dropped
      @(posedge clk); #1;
      exp_s.push_back('{owner: 1'b0, addr: 30'h44, wdata: '0, wstrb: 4'h0});
      mv[0] = 1'b1; ma[0] = 30'h44; dir_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mv[0] = 1'b0; ma[0] = '0; dir_ready = 1'b0;
      @(negedge clk);
      check("abort_in_wait", 64'(busy_o), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("abort_rst_state", 64'({busy_o, grant_o, s_valid_o, m0_ready_o, m1_ready_o}), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      model_ptr = 1'b0;
      @(posedge clk); #1;
      dir_rvalid = 1'b1; dir_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check("abort_no_rvalid", 64'({m1_rvalid_o, m0_rvalid_o, m0_rdata_o}), 64'd0);
      check("abort_idle", 64'({busy_o, grant_o}), 64'd0);
      @(posedge clk); #1;
      dir_rvalid = 1'b0;

      // Both requesters holding four requests each
      cache_auto = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rq[0].push_back(rnd_req());
         rq[1].push_back(rnd_req());
      end
      run_round();

      for (int r = 0; r < 40; r++) begin
         int mask;
         mask = $urandom_range(1, 3);
         for (int id = 0; id < 2; id++)
            if (mask[id]) begin
               int n;
               n = $urandom_range(1, 3);
               for (int j = 0; j < n; j++) rq[id].push_back(rnd_req());
            end
         run_round();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/iob_port_arbiter.md
IOB_PORT_ARBITER -- requirements
Module: iob_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, meaning the word address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width; the wstrb width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have m0_valid_i/m0_addr_i/m0_wdata_i/m0_wstrb_i, inputs, 1/ADDR_W/DATA_W/DATA_W/8 bits: requester 0 (CPU data port) request.
REQ-006 SHALL have m0_ready_o/m0_rvalid_o/m0_rdata_o, outputs, 1/1/DATA_W bits: requester 0 accept and read return.
REQ-007 SHALL have m1_* with the same directions and widths as m0_*: requester 1 (CPU instruction fetch).
REQ-008 SHALL have s_valid_o/s_addr_o/s_wdata_o/s_wstrb_o, outputs, 1/ADDR_W/DATA_W/DATA_W/8 bits: request to the shared cache front end.
REQ-009 SHALL have s_ready_i/s_rvalid_i/s_rdata_i, inputs, 1/1/DATA_W bits: cache accept and read return.
REQ-010 SHALL have grant_o, output, 2 bits: one-hot owner of the current transaction, or 00 when idle.
REQ-011 SHALL have busy_o, output, 1 bit: high when the state is not IDLE.

Function
REQ-012 SHALL be a 3-state FSM with states IDLE, ISSUE and WAIT_RD, with at most one outstanding transaction.
REQ-013 In IDLE with any mX_valid_i high, SHALL pick a winner (REQ-022), latch its addr/wdata/wstrb and owner, and go to ISSUE on the next edge.
REQ-014 In ISSUE, SHALL drive s_valid_o=1 and the s_addr_o/s_wdata_o/s_wstrb_o fields from the latched values; request-to-s_valid_o latency is exactly 1 cycle.
REQ-015 In ISSUE, the owner's mX_ready_o SHALL equal s_ready_i combinationally; the non-owner's ready SHALL stay 0.
REQ-016 On an ISSUE cycle with s_ready_i=1: a write (wstrb!=0) SHALL go to IDLE; a read (wstrb==0) SHALL go to WAIT_RD.
REQ-017 In WAIT_RD, the owner's mX_rvalid_o SHALL equal s_rvalid_i and its mX_rdata_o SHALL equal s_rdata_i; on s_rvalid_i=1 the FSM SHALL go to IDLE.
REQ-018 Non-owner rvalid SHALL be 0 and its rdata SHALL be 0; s_rvalid_i outside WAIT_RD SHALL be ignored.
REQ-019 Requesters SHALL hold valid and all fields until ready; the arbiter SHALL not re-sample the owner's inputs after latching.
REQ-020 s_valid_o, s_addr_o, s_wdata_o and s_wstrb_o SHALL be 0 outside ISSUE.
REQ-021 A request arriving in ISSUE or WAIT_RD SHALL wait without loss; the earliest possible back-to-back re-issue is IDLE -> ISSUE one cycle after completion.
REQ-022 Fixed priority (macro absent): when both requesters are valid in IDLE, m0 SHALL win.

Reset
REQ-023 reset_n low SHALL, asynchronously and at any point mid-transaction, force IDLE and set grant_o=00, busy_o=0, all ready/rvalid=0, all rdata=0 and all s_* outputs to 0; the round-robin pointer SHALL be set to favour m0.
REQ-024 An aborted in-flight transaction SHALL be dropped; no rvalid SHALL be forwarded for it after reset release.

Configuration
REQ-025 Macro IOB_ARB_RR_EN defined: on simultaneous requests in IDLE the winner SHALL be the requester not granted last, via a 1-bit pointer updated at each grant.
REQ-026 Macro IOB_ARB_RR_EN undefined: REQ-022 fixed priority SHALL apply and the pointer logic SHALL be omitted.

Verification
REQ-027 Read m0 addr=0x10, s_ready_i=1 first cycle, s_rvalid_i 2 cycles later with rdata=0xDEADBEEF -> s_valid_o high 1 cycle, m0_rvalid_o=1 with 0xDEADBEEF, m1 outputs stay 0.
REQ-028 Write m1 addr=0x20, wdata=0x12345678, wstrb=0xF, s_ready_i held low 3 cycles -> s_valid_o and fields stable 4 cycles, m1_ready_o=1 on cycle 4, then IDLE without entering WAIT_RD.
REQ-029 Both valid in IDLE for 4 transactions -> fixed: order m0,m0,m0,m0 while m0 stays valid; IOB_ARB_RR_EN: order m0,m1,m0,m1.
REQ-030 reset_n low during WAIT_RD, then s_rvalid_i=1 after release -> no mX_rvalid_o, grant_o=00, busy_o=0.
REQ-031 Spurious s_rvalid_i=1 in IDLE and ISSUE -> both mX_rvalid_o stay 0 and the state is unchanged.
